// File: rtl/serial_memory_loader.sv
// serial_memory_loader: byte-stream command front end that pauses the
// processor and performs word writes/reads on its external memory port.
// Commands: 'P' set pause, 'R' clear pause, 'W' addr[4] data[4] write,
// 'L' addr[4] read (answered with the 4 data bytes, MSB first).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   rx_*            inbound byte stream (valid/ready)
//   tx_*            outbound response stream (valid/ready)
//   pause           processor pause request
//   mem_*           external memory control, address, data and modes
//   mem_data_in     read data returned by the memory
//   busy            high whenever the command FSM is not idle
module serial_memory_loader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter logic [2:0]  MODE_WORD      = 3'd3,
  parameter logic [2:0]  MODE_NONE      = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        pause,
  output logic        mem_ctrl,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [2:0]  mem_read_mode,
  output logic [2:0]  mem_write_mode,
  input  logic [31:0] mem_data_in,
  output logic        busy
);

  localparam logic [7:0] CMD_PAUSE  = 8'h50;
  localparam logic [7:0] CMD_RESUME = 8'h52;
  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_LOAD   = 8'h4C;
  localparam logic [7:0] RSP_ACK    = 8'h06;
  localparam logic [7:0] RSP_NAK    = 8'h15;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, WRITE, READ0, READ1, SEND, RESP
  } state_t;

  state_t      state;
  logic [1:0]  byteCnt;
  logic        isWrite;
  logic [31:0] addrShift;
  logic [23:0] dataShift;
  logic [31:0] readShift;
  logic [31:0] timer;

  // Handshake, busy and memory strobes are pure decodes of the state flops.
  assign rx_ready       = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
  assign tx_valid       = (state == SEND) || (state == RESP);
  assign busy           = (state != IDLE);
  assign mem_ctrl       = (state == WRITE) || (state == READ0) || (state == READ1);
  assign mem_write_mode = (state == WRITE) ? MODE_WORD : MODE_NONE;
  assign mem_read_mode  = ((state == READ0) || (state == READ1)) ? MODE_WORD : MODE_NONE;

  // Command FSM with payload assembly, inter-byte timeout and response path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      byteCnt     <= 2'd0;
      isWrite     <= 1'b0;
      addrShift   <= 32'd0;
      dataShift   <= 24'd0;
      readShift   <= 32'd0;
      timer       <= 32'd0;
      tx_data     <= 8'd0;
      pause       <= 1'b0;
      mem_address <= 32'd0;
      mem_data    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            byteCnt <= 2'd0;
            timer   <= 32'd0;
            case (rx_data)
              CMD_PAUSE: begin
                pause   <= 1'b1;
                tx_data <= RSP_ACK;
                state   <= RESP;
              end
              CMD_RESUME: begin
                pause   <= 1'b0;
                tx_data <= RSP_ACK;
                state   <= RESP;
              end
              CMD_WRITE, CMD_LOAD: begin
                // Memory commands are refused unless the processor is paused.
                if (pause) begin
                  isWrite <= (rx_data == CMD_WRITE);
                  state   <= GET_ADDR;
                end else begin
                  tx_data <= RSP_NAK;
                  state   <= RESP;
                end
              end
              default: begin
                tx_data <= RSP_NAK;
                state   <= RESP;
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            timer     <= 32'd0;
            byteCnt   <= byteCnt + 2'd1;
            addrShift <= {addrShift[23:0], rx_data};
            if (byteCnt == 2'd3) begin
              if (isWrite) begin
                state <= GET_DATA;
              end else begin
                mem_address <= {addrShift[23:0], rx_data};
                state       <= READ0;
              end
            end
          end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
            tx_data <= RSP_NAK;
            state   <= RESP;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            timer     <= 32'd0;
            byteCnt   <= byteCnt + 2'd1;
            dataShift <= {dataShift[15:0], rx_data};
            // Address/data outputs only move once the whole packet is in.
            if (byteCnt == 2'd3) begin
              mem_address <= addrShift;
              mem_data    <= {dataShift, rx_data};
              state       <= WRITE;
            end
          end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
            tx_data <= RSP_NAK;
            state   <= RESP;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WRITE: begin
          tx_data <= RSP_ACK;
          state   <= RESP;
        end
        READ0: state <= READ1;
        READ1: begin
          // First byte goes straight to tx_data; the rest queue up MSB first.
          tx_data   <= mem_data_in[31:24];
          readShift <= {mem_data_in[23:0], 8'h00};
          byteCnt   <= 2'd0;
          state     <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (byteCnt == 2'd3) begin
              state <= IDLE;
            end else begin
              byteCnt   <= byteCnt + 2'd1;
              tx_data   <= readShift[31:24];
              readShift <= {readShift[23:0], 8'h00};
            end
          end
        end
        RESP: begin
          if (tx_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_memory_loader.sv
// Directed bench for serial_memory_loader: pause/resume, word write, word
// read with a stalled transmitter, NAK paths, timeout and mid-packet reset.
module tb_serial_memory_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        pause;
  logic        mem_ctrl;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [2:0]  mem_read_mode;
  logic [2:0]  mem_write_mode;
  logic [31:0] mem_data_in;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;

  // Memory-port activity seen on the falling edge.
  int          ctrlCycles = 0;
  int          wrPulses = 0;
  int          rdPulses = 0;
  logic [31:0] lastWrAddr = 32'd0;
  logic [31:0] lastWrData = 32'd0;
  logic [31:0] lastRdAddr = 32'd0;

  serial_memory_loader #(
    .TIMEOUT_CYCLES(32'd16),
    .MODE_WORD     (3'd3),
    .MODE_NONE     (3'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .pause         (pause),
    .mem_ctrl      (mem_ctrl),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_read_mode (mem_read_mode),
    .mem_write_mode(mem_write_mode),
    .mem_data_in   (mem_data_in),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_ctrl) begin
      ctrlCycles++;
      if (mem_write_mode == 3'd3 && mem_read_mode == 3'd0) begin
        wrPulses++;
        lastWrAddr = mem_address;
        lastWrData = mem_data;
      end
      if (mem_read_mode == 3'd3 && mem_write_mode == 3'd0) begin
        rdPulses++;
        lastRdAddr = mem_address;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Present one byte and hold it until the loader takes it.
  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      testsRun++;
      testsFailed++;
      $display("FAIL send_%02h: rx_ready stayed 0 for %0d cycles, required 1", b, n);
    end else begin
      @(posedge clk);
    end
    #1;
    rx_valid = 1'b0;
  endtask

  // Wait for a response byte, take it, and report how long it took.
  task automatic recvByte(output logic [7:0] b, output int waited);
    waited = 0;
    b = 8'h00;
    @(negedge clk);
    while (!tx_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_valid) begin
      testsRun++;
      testsFailed++;
      $display("FAIL recv_wait: tx_valid stayed 0 for %0d cycles, required 1", waited);
    end else begin
      b = tx_data;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b0;
    mem_data_in = 32'h0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({pause, mem_ctrl, busy, tx_valid} !== 4'b0000) begin
      testsFailed++;
      $display("FAIL reset_flags: pause/mem_ctrl/busy/tx_valid=%b required 0000",
               {pause, mem_ctrl, busy, tx_valid});
    end
    testsRun++;
    if (mem_address !== 32'd0 || mem_data !== 32'd0 || tx_data !== 8'd0) begin
      testsFailed++;
      $display("FAIL reset_values: addr=%h data=%h tx_data=%h required zeros",
               mem_address, mem_data, tx_data);
    end
    testsRun++;
    if (mem_read_mode !== 3'd0 || mem_write_mode !== 3'd0) begin
      testsFailed++;
      $display("FAIL reset_modes: read=%0d write=%0d required 0 0", mem_read_mode, mem_write_mode);
    end
    rst = 1'b1;
    @(negedge clk);
    testsRun++;
    if (rx_ready !== 1'b1) begin
      testsFailed++;
      $display("FAIL idle_rx_ready: got %b required 1", rx_ready);
    end
  endtask

  task automatic test_pause_ack;
    logic [7:0] b;
    int w;
    sendByte(8'h50);
    testsRun++;
    if (pause !== 1'b1) begin
      testsFailed++;
      $display("FAIL pause_set: got %b required 1", pause);
    end
    testsRun++;
    if (busy !== 1'b1 || rx_ready !== 1'b0) begin
      testsFailed++;
      $display("FAIL resp_state: busy=%b rx_ready=%b required 1 0", busy, rx_ready);
    end
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h06) begin
      testsFailed++;
      $display("FAIL pause_ack: got %h required 06", b);
    end
  endtask

  task automatic test_unknown;
    logic [7:0] b;
    int w;
    sendByte(8'h99);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h15) begin
      testsFailed++;
      $display("FAIL unknown_nak: got %h required 15", b);
    end
    testsRun++;
    if (pause !== 1'b1) begin
      testsFailed++;
      $display("FAIL unknown_pause: got %b required 1", pause);
    end
  endtask

  task automatic test_write;
    logic [7:0] pkt [9];
    logic [7:0] b;
    int w;
    int c0;
    int wr0;
    pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    c0 = ctrlCycles;
    wr0 = wrPulses;
    for (int i = 0; i < 9; i++) sendByte(pkt[i]);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h06) begin
      testsFailed++;
      $display("FAIL write_ack: got %h required 06", b);
    end
    testsRun++;
    if (ctrlCycles - c0 != 1 || wrPulses - wr0 != 1) begin
      testsFailed++;
      $display("FAIL write_pulse: ctrl cycles=%0d write cycles=%0d required 1 1",
               ctrlCycles - c0, wrPulses - wr0);
    end
    testsRun++;
    if (lastWrAddr !== 32'h0000_0010 || lastWrData !== 32'hDEAD_BEEF) begin
      testsFailed++;
      $display("FAIL write_payload: addr=%h data=%h required 00000010 deadbeef",
               lastWrAddr, lastWrData);
    end
    testsRun++;
    if (mem_address !== 32'h0000_0010 || mem_data !== 32'hDEAD_BEEF || mem_ctrl !== 1'b0) begin
      testsFailed++;
      $display("FAIL write_hold: addr=%h data=%h ctrl=%b required 00000010 deadbeef 0",
               mem_address, mem_data, mem_ctrl);
    end
  endtask

  task automatic test_read;
    logic [7:0] pkt [5];
    logic [7:0] exp [4];
    logic [7:0] b;
    int w;
    int c0;
    int rd0;
    logic stableBad;
    pkt = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h10};
    exp = '{8'h12, 8'h34, 8'h56, 8'h78};
    mem_data_in = 32'h1234_5678;
    c0 = ctrlCycles;
    rd0 = rdPulses;
    for (int i = 0; i < 5; i++) sendByte(pkt[i]);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        stableBad = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (tx_valid !== 1'b1 || tx_data !== 8'h34) stableBad = 1'b1;
        end
        testsRun++;
        if (stableBad) begin
          testsFailed++;
          $display("FAIL read_stall: tx_valid=%b tx_data=%h required 1 34", tx_valid, tx_data);
        end
      end
      recvByte(b, w);
      testsRun++;
      if (b !== exp[i]) begin
        testsFailed++;
        $display("FAIL read_byte%0d: got %h required %h", i, b, exp[i]);
      end
    end
    @(negedge clk);
    testsRun++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL read_no_ack: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
    end
    testsRun++;
    if (ctrlCycles - c0 != 2 || rdPulses - rd0 != 2 || lastRdAddr !== 32'h0000_0010) begin
      testsFailed++;
      $display("FAIL read_pulse: ctrl=%0d read=%0d addr=%h required 2 2 00000010",
               ctrlCycles - c0, rdPulses - rd0, lastRdAddr);
    end
    mem_data_in = 32'h0;
  endtask

  task automatic test_nak_unpaused;
    logic [7:0] b;
    int w;
    int c0;
    sendByte(8'h52);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h06 || pause !== 1'b0) begin
      testsFailed++;
      $display("FAIL resume: byte=%h pause=%b required 06 0", b, pause);
    end
    c0 = ctrlCycles;
    sendByte(8'h57);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h15) begin
      testsFailed++;
      $display("FAIL unpaused_nak: got %h required 15", b);
    end
    @(negedge clk);
    testsRun++;
    if (rx_ready !== 1'b1 || busy !== 1'b0 || ctrlCycles != c0) begin
      testsFailed++;
      $display("FAIL unpaused_idle: rx_ready=%b busy=%b ctrl cycles=%0d required 1 0 0",
               rx_ready, busy, ctrlCycles - c0);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    int w;
    int c0;
    sendByte(8'h50);
    recvByte(b, w);
    c0 = ctrlCycles;
    sendByte(8'h57);
    sendByte(8'h00);
    sendByte(8'h00);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h15) begin
      testsFailed++;
      $display("FAIL timeout_nak: got %h required 15", b);
    end
    testsRun++;
    if (w < 15 || w > 17) begin
      testsFailed++;
      $display("FAIL timeout_delay: waited %0d cycles required about 16", w);
    end
    testsRun++;
    if (ctrlCycles != c0 || pause !== 1'b1) begin
      testsFailed++;
      $display("FAIL timeout_side: ctrl cycles=%0d pause=%b required 0 1", ctrlCycles - c0, pause);
    end
    sendByte(8'h52);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h06 || pause !== 1'b0) begin
      testsFailed++;
      $display("FAIL timeout_resume: byte=%h pause=%b required 06 0", b, pause);
    end
  endtask

  task automatic test_reset_midpacket;
    logic [7:0] pkt [6];
    logic [7:0] b;
    int w;
    pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hAA};
    sendByte(8'h50);
    recvByte(b, w);
    for (int i = 0; i < 6; i++) sendByte(pkt[i]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    testsRun++;
    if ({pause, mem_ctrl, busy, tx_valid} !== 4'b0000 || tx_data !== 8'd0) begin
      testsFailed++;
      $display("FAIL midreset_flags: pause/ctrl/busy/tx_valid=%b tx_data=%h required 0000 00",
               {pause, mem_ctrl, busy, tx_valid}, tx_data);
    end
    testsRun++;
    if (mem_address !== 32'd0 || mem_data !== 32'd0 ||
        mem_read_mode !== 3'd0 || mem_write_mode !== 3'd0) begin
      testsFailed++;
      $display("FAIL midreset_mem: addr=%h data=%h modes=%0d/%0d required 0",
               mem_address, mem_data, mem_read_mode, mem_write_mode);
    end
    @(negedge clk);
    rst = 1'b1;
    sendByte(8'h50);
    recvByte(b, w);
    testsRun++;
    if (b !== 8'h06 || pause !== 1'b1) begin
      testsFailed++;
      $display("FAIL fresh_cmd: byte=%h pause=%b required 06 1", b, pause);
    end
  endtask

  initial begin
    test_reset();
    test_pause_ack();
    test_unknown();
    test_write();
    test_read();
    test_nak_unpaused();
    test_timeout();
    test_reset_midpacket();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/serial_memory_loader.md
SERIAL_MEMORY_LOADER -- requirements
Module: serial_memory_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd1000000, max clk cycles allowed between bytes inside one packet.
REQ-002 Parameter MODE_WORD, default 3'd3, read/write mode code for a 32-bit word access.
REQ-003 Parameter MODE_NONE, default 3'd0, read/write mode code for no access.
REQ-004 Reset rst is asynchronous and active-low; clock is clk.
REQ-005 clk  in  1  system clock, same clock as the processor's clk.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 rx_data  in  8  byte from the UART receiver.
REQ-008 rx_valid  in  1  rx_data valid; a byte transfers when rx_valid & rx_ready.
REQ-009 rx_ready  out  1  loader can accept a byte.
REQ-010 tx_data  out  8  response byte to the UART transmitter.
REQ-011 tx_valid  out  1  tx_data valid; a byte transfers when tx_valid & tx_ready.
REQ-012 tx_ready  in  1  transmitter accepts a byte.
REQ-013 pause  out  1  drives the processor pause input.
REQ-014 mem_ctrl  out  1  drives externalMemoryControl.
REQ-015 mem_address  out  32  drives externalAddress.
REQ-016 mem_data  out  32  drives externalData.
REQ-017 mem_read_mode, mem_write_mode  out  3 each  drive externalReadMode and externalWriteMode.
REQ-018 mem_data_in  in  32  driven by externalDataOut.
REQ-019 busy  out  1  high in every state other than IDLE.

Function
REQ-020 Commands SHALL be decoded from the first byte:
- 0x50 'P': set pause.
- 0x52 'R': clear pause.
- 0x57 'W': followed by 4 address bytes then 4 data bytes.
- 0x4C 'L': followed by 4 address bytes.
- Multi-byte fields are big-endian, MSB first.
REQ-021 FSM states: IDLE, GET_ADDR, GET_DATA, WRITE, READ0, READ1, SEND, RESP; a 2-bit byte counter indexes the field bytes.
REQ-022 rx_ready SHALL be 1 only in IDLE, GET_ADDR and GET_DATA.
REQ-023 tx_valid SHALL be 1 only in SEND and RESP; tx_data SHALL be held stable until the byte transfers.
REQ-024 P and R SHALL update pause on the cycle after the command byte transfers, then go to RESP with 0x06 (ACK).
REQ-025 W or L received while pause=0 SHALL go to RESP with 0x15 (NAK) and consume no payload bytes.
REQ-026 An unknown command byte SHALL go to RESP with 0x15.
REQ-027 WRITE SHALL last exactly one clk cycle:
- mem_ctrl=1, mem_write_mode=MODE_WORD, mem_read_mode=MODE_NONE.
- mem_address and mem_data hold the assembled values.
- Then RESP with 0x06.
REQ-028 READ0 and READ1 SHALL last one cycle each with mem_ctrl=1 and mem_read_mode=MODE_WORD.
REQ-029 On the READ1 clock edge, mem_data_in SHALL be captured into a 32-bit shift register.
REQ-030 SEND SHALL transmit the 4 captured bytes MSB first, then return to IDLE; no ACK follows a read.
REQ-031 Outside WRITE, READ0 and READ1, mem_ctrl SHALL be 0 and both mode outputs SHALL be MODE_NONE.
REQ-032 mem_address and mem_data SHALL hold their last values.
REQ-033 RESP SHALL return to IDLE on the cycle its byte transfers.
REQ-034 Inter-byte timeout:
- In GET_ADDR and GET_DATA, a counter SHALL clear on every accepted byte.
- Reaching TIMEOUT_CYCLES SHALL discard the partial packet and go to RESP with 0x15.
- No memory access SHALL occur on timeout.
REQ-035 While tx_ready=0, SEND and RESP SHALL stall indefinitely; the timeout does not apply.
REQ-036 pause SHALL remain set across W and L commands, NAKs and timeouts.

Reset
REQ-037 On rst=0, outputs SHALL immediately take these values:
- pause=0, mem_ctrl=0.
- mem_address=0, mem_data=0.
- Both modes=MODE_NONE.
- tx_valid=0, tx_data=0.
- busy=0.
REQ-038 On rst=0, the FSM SHALL go to IDLE with the counters and shift register cleared; a packet in progress is dropped without a response.

Verification
REQ-039 Bytes 50 -> pause=1 and tx 06. Then bytes 57 00 00 00 10 DE AD BE EF -> exactly one cycle with mem_ctrl=1, mem_write_mode=3, address 0x10, data 0xDEADBEEF, then tx 06.
REQ-040 With pause=1, bytes 4C 00 00 00 10 and mem_data_in=0x12345678 during READ1 -> tx 12 34 56 78 in order; hold tx_ready=0 for 5 cycles mid-stream and tx_data stays stable.
REQ-041 With pause=0, byte 57 -> tx 15, rx_ready high again in IDLE, no mem_ctrl pulse.
REQ-042 With TIMEOUT_CYCLES=16, send 57 00 00 then idle for 16 cycles -> tx 15, no write; a following 52 -> pause=0 and tx 06.
REQ-043 Assert rst after 57 00 00 00 04 AA -> all outputs at reset values; a following 50 is decoded as a fresh command.
REQ-044 Byte 99 -> tx 15; pause unchanged.
